// File: rtl/par_sink_arbiter.sv
// Round-robin arbiter sharing one item/valid/busy sink channel among n_ports sources,
// with a one-entry output register, forwarded-item counter and sticky stall flag.
`ifndef HDR_SZ
`define HDR_SZ 8
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 8
`endif

module par_sink_arbiter #(
  parameter int id        = -1,
  parameter int n_ports   = 4,
  parameter int max_stall = 16,
  localparam int ITEM_W   = `HDR_SZ + `PL_SZ + `ADDR_SZ
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [n_ports*ITEM_W-1:0]   item_in,
  input  logic [n_ports-1:0]          valid,
  output logic [n_ports-1:0]          channel_busy,
  output logic [ITEM_W-1:0]           item_out,
  output logic                        valid_out,
  input  logic                        sink_busy,
  output logic [2:0]                  src_out,
  output logic [15:0]                 fwd_count,
  output logic                        stall_err
);

  localparam logic [2:0] LAST_PORT = 3'(n_ports - 1);
  localparam logic [7:0] STALL_MAX = 8'(max_stall);

  if (n_ports < 2 || n_ports > 8 || max_stall < 1 || max_stall > 255 || id < -1) begin : g_bad_params
    $error("par_sink_arbiter: parameter out of range");
  end

  logic [ITEM_W-1:0]  r_item_out;
  logic               r_valid_out;
  logic [2:0]         r_src_out;
  logic [15:0]        r_fwd_count;
  logic               r_stall_err;
  logic [2:0]         r_rr_ptr;
  logic [7:0]         r_stall_cnt;

  logic               w_can_load;
  logic               w_drain;
  logic               w_blocked;
  logic               w_load;
  logic               w_hi_found;
  logic               w_lo_found;
  logic [2:0]         w_hi;
  logic [2:0]         w_lo;
  logic               w_found;
  logic [2:0]         w_winner;
  logic [ITEM_W-1:0]  w_win_item;
  logic [n_ports-1:0] w_busy;

  assign w_can_load = !r_valid_out || !sink_busy;
  assign w_drain    = r_valid_out && !sink_busy;
  assign w_blocked  = r_valid_out && sink_busy;

  // Rotating priority: first requester at or above rr_ptr wins, else the lowest one below it.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int i = 0; i < n_ports; i++) begin
      if (valid[i]) begin
        if (3'(i) >= r_rr_ptr) begin
          if (!w_hi_found) begin
            w_hi_found = 1'b1;
            w_hi       = 3'(i);
          end
        end else if (!w_lo_found) begin
          w_lo_found = 1'b1;
          w_lo       = 3'(i);
        end
      end
    end
    w_found  = w_hi_found || w_lo_found;
    w_winner = w_hi_found ? w_hi : w_lo;
    w_load   = w_found && w_can_load;
  end

  always_comb begin
    w_win_item = '0;
    w_busy     = '1;
    for (int i = 0; i < n_ports; i++) begin
      if (w_winner == 3'(i)) begin
        w_win_item = item_in[i*ITEM_W +: ITEM_W];
        w_busy[i]  = !w_load;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_item_out  <= '0;
      r_valid_out <= 1'b0;
      r_src_out   <= '0;
      r_fwd_count <= '0;
      r_stall_err <= 1'b0;
      r_rr_ptr    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_load) begin
        r_item_out  <= w_win_item;
        r_valid_out <= 1'b1;
        r_src_out   <= w_winner;
        r_rr_ptr    <= (w_winner == LAST_PORT) ? 3'd0 : w_winner + 3'd1;
      end else if (w_drain) begin
        r_valid_out <= 1'b0;
      end

      if (w_drain) begin
        r_fwd_count <= r_fwd_count + 16'd1;
      end

      // The flag rises on the same edge the counter reaches max_stall.
      if (w_blocked) begin
        if (r_stall_cnt != STALL_MAX) begin
          r_stall_cnt <= r_stall_cnt + 8'd1;
        end
        if (r_stall_cnt >= STALL_MAX - 8'd1) begin
          r_stall_err <= 1'b1;
        end
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

  assign channel_busy = reset ? w_busy : '1;
  assign item_out     = r_item_out;
  assign valid_out    = r_valid_out;
  assign src_out      = r_src_out;
  assign fwd_count    = r_fwd_count;
  assign stall_err    = r_stall_err;

endmodule

// File: tb/tb_par_sink_arbiter.sv
// Bench for par_sink_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic against a behavioural model of the arbitration rules.
`ifndef HDR_SZ
`define HDR_SZ 8
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 8
`endif

module tb_par_sink_arbiter;

  localparam int NP    = 4;
  localparam int MAXST = 4;
  localparam int IW    = `HDR_SZ + `PL_SZ + `ADDR_SZ;

  logic              clk;
  logic              reset;
  logic [NP*IW-1:0]  item_in;
  logic [NP-1:0]     valid;
  logic [NP-1:0]     channel_busy;
  logic [IW-1:0]     item_out;
  logic              valid_out;
  logic              sink_busy;
  logic [2:0]        src_out;
  logic [15:0]       fwd_count;
  logic              stall_err;

  par_sink_arbiter #(.id(-1), .n_ports(NP), .max_stall(MAXST)) dut (
    .clk          (clk),
    .reset        (reset),
    .item_in      (item_in),
    .valid        (valid),
    .channel_busy (channel_busy),
    .item_out     (item_out),
    .valid_out    (valid_out),
    .sink_busy    (sink_busy),
    .src_out      (src_out),
    .fwd_count    (fwd_count),
    .stall_err    (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [IW-1:0] m_item;
  logic          m_vld;
  int            m_src;
  logic [15:0]   m_fwd;
  logic          m_err;
  int            m_ptr;
  int            m_run;
  // Model next-state and expected combinational output
  logic [NP-1:0] e_busy;
  logic [IW-1:0] n_item;
  logic          n_vld;
  int            n_src;
  logic [15:0]   n_fwd;
  logic          n_err;
  int            n_ptr;
  int            n_run;

  typedef struct {
    bit          rst;
    logic [3:0]  v;
    logic        sb;
    logic [3:0]  busy;
    logic        vout;
    logic [2:0]  src;
    logic [15:0] fwd;
    logic        err;
    logic [7:0]  pl;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_item = '0; m_vld = 1'b0; m_src = 0; m_fwd = '0;
    m_err = 1'b0; m_ptr = 0; m_run = 0;
  endtask

  task automatic m_eval();
    int  win;
    bit  ld;
    win = -1;
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (m_ptr + k) % NP;
      if (win < 0 && valid[p]) win = p;
    end
    ld = (!m_vld || !sink_busy) && (win >= 0);
    e_busy = '1;
    if (ld) e_busy[win] = 1'b0;
    n_run = (m_vld && sink_busy) ? m_run + 1 : 0;
    n_err = m_err || (n_run >= MAXST);
    n_fwd = m_fwd + ((m_vld && !sink_busy) ? 16'd1 : 16'd0);
    n_item = m_item; n_src = m_src; n_ptr = m_ptr;
    if (ld) begin
      n_item = item_in[win*IW +: IW];
      n_vld  = 1'b1;
      n_src  = win;
      n_ptr  = (win + 1) % NP;
    end else begin
      n_vld  = m_vld && sink_busy;
    end
  endtask

  task automatic apply(input logic [3:0] v, input logic sb, input bit cmp);
    valid = v;
    sink_busy = sb;
    #3;
    m_eval();
    if (cmp) begin
      chk("busy", 32'(channel_busy), 32'(e_busy));
      chk("valid_out", 32'(valid_out), 32'(m_vld));
      chk("item_out", 32'(item_out), 32'(m_item));
      chk("src_out", 32'(src_out), 32'(m_src));
      chk("fwd_count", 32'(fwd_count), 32'(m_fwd));
      chk("stall_err", 32'(stall_err), 32'(m_err));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_item = n_item; m_vld = n_vld; m_src = n_src; m_fwd = n_fwd;
    m_err = n_err; m_ptr = n_ptr; m_run = n_run;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    m_reset();
    chk("rst_busy", 32'(channel_busy), 32'hF);
    chk("rst_vout", 32'(valid_out), 32'h0);
    chk("rst_fwd", 32'(fwd_count), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic fixed_items();
    for (int i = 0; i < NP; i++)
      item_in[i*IW +: IW] = {8'(8'hA0 + i), 8'(8'h58 + i), 8'(8'h10 + i)};
  endtask

  task automatic random_items();
    for (int i = 0; i < NP; i++)
      item_in[i*IW +: IW] = IW'($urandom);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b0; valid = '0; sink_busy = 1'b0; item_in = '0;
    m_reset();

    // Reset then idle
    repeat (3) begin
      @(negedge clk);
      chk("reset_busy", 32'(channel_busy), 32'hF);
      chk("reset_vout", 32'(valid_out), 32'h0);
      chk("reset_err", 32'(stall_err), 32'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) begin
      apply(4'b0000, 1'b0, 1'b1);
      chk("idle_busy", 32'(channel_busy), 32'hF);
      advance();
    end

    // rst, valid, sink_busy | busy, vout, src, fwd, err, payload
    tbl.push_back('{0, 4'b0100, 0, 4'b1011, 0, 3'd0, 16'd0, 0, 8'h00});
    tbl.push_back('{0, 4'b0000, 0, 4'b1111, 1, 3'd2, 16'd0, 0, 8'h5A});
    tbl.push_back('{0, 4'b0000, 0, 4'b1111, 0, 3'd2, 16'd1, 0, 8'h5A});
    tbl.push_back('{1, 4'b1111, 0, 4'b1110, 0, 3'd0, 16'd0, 0, 8'h00});
    tbl.push_back('{0, 4'b1111, 0, 4'b1101, 1, 3'd0, 16'd0, 0, 8'h58});
    tbl.push_back('{0, 4'b1111, 0, 4'b1011, 1, 3'd1, 16'd1, 0, 8'h59});
    tbl.push_back('{0, 4'b1111, 0, 4'b0111, 1, 3'd2, 16'd2, 0, 8'h5A});
    tbl.push_back('{0, 4'b1111, 0, 4'b1110, 1, 3'd3, 16'd3, 0, 8'h5B});
    tbl.push_back('{0, 4'b1111, 0, 4'b1101, 1, 3'd0, 16'd4, 0, 8'h58});
    tbl.push_back('{0, 4'b1111, 0, 4'b1011, 1, 3'd1, 16'd5, 0, 8'h59});
    tbl.push_back('{0, 4'b1111, 0, 4'b0111, 1, 3'd2, 16'd6, 0, 8'h5A});
    tbl.push_back('{0, 4'b0000, 0, 4'b1111, 1, 3'd3, 16'd7, 0, 8'h5B});
    tbl.push_back('{0, 4'b0000, 0, 4'b1111, 0, 3'd3, 16'd8, 0, 8'h5B});
    tbl.push_back('{0, 4'b0011, 0, 4'b1110, 0, 3'd3, 16'd8, 0, 8'h5B});
    tbl.push_back('{0, 4'b0011, 1, 4'b1111, 1, 3'd0, 16'd8, 0, 8'h58});
    tbl.push_back('{0, 4'b0011, 1, 4'b1111, 1, 3'd0, 16'd8, 0, 8'h58});
    tbl.push_back('{0, 4'b0011, 1, 4'b1111, 1, 3'd0, 16'd8, 0, 8'h58});
    tbl.push_back('{0, 4'b0011, 1, 4'b1111, 1, 3'd0, 16'd8, 0, 8'h58});
    tbl.push_back('{0, 4'b0011, 1, 4'b1111, 1, 3'd0, 16'd8, 1, 8'h58});
    tbl.push_back('{0, 4'b0011, 0, 4'b1101, 1, 3'd0, 16'd8, 1, 8'h58});
    tbl.push_back('{0, 4'b0011, 0, 4'b1110, 1, 3'd1, 16'd9, 1, 8'h59});
    tbl.push_back('{0, 4'b0000, 0, 4'b1111, 1, 3'd0, 16'd10, 1, 8'h58});
    tbl.push_back('{0, 4'b0000, 0, 4'b1111, 0, 3'd0, 16'd11, 1, 8'h58});

    fixed_items();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i].v, tbl[i].sb, 1'b1);
      chk($sformatf("tbl%0d_busy", i), 32'(channel_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_vout", i), 32'(valid_out), 32'(tbl[i].vout));
      chk($sformatf("tbl%0d_src", i), 32'(src_out), 32'(tbl[i].src));
      chk($sformatf("tbl%0d_fwd", i), 32'(fwd_count), 32'(tbl[i].fwd));
      chk($sformatf("tbl%0d_err", i), 32'(stall_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_pl", i), 32'(item_out[`ADDR_SZ +: `PL_SZ]), 32'(tbl[i].pl));
      advance();
    end

    // Stall flag stays set after backpressure lifts
    repeat (3) begin
      apply(4'b0000, 1'b0, 1'b1);
      chk("err_sticky", 32'(stall_err), 32'h1);
      advance();
    end

    // Randomized traffic, including long busy bursts
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      logic sb;
      random_items();
      sb = ((c / 50) % 4 == 3) ? 1'b1 : ($urandom_range(0, 9) < 4);
      apply(4'($urandom), sb, 1'b1);
      advance();
    end

    // Counter wrap
    do_reset();
    fixed_items();
    guard = 0;
    while (m_fwd != 16'hFFFF && guard < 70000) begin
      apply(4'b1111, 1'b0, 1'b0);
      advance();
      guard++;
    end
    apply(4'b1111, 1'b0, 1'b1);
    chk("wrap_pre", 32'(fwd_count), 32'hFFFF);
    advance();
    apply(4'b0000, 1'b0, 1'b1);
    chk("wrap_zero", 32'(fwd_count), 32'h0);
    advance();
    apply(4'b0000, 1'b0, 1'b1);
    advance();

    // Reset while the output slot is blocked
    item_in[1*IW +: IW] = 24'hC3E7_5D;
    apply(4'b0010, 1'b0, 1'b1);
    advance();
    apply(4'b0000, 1'b1, 1'b1);
    chk("held_vout", 32'(valid_out), 32'h1);
    advance();
    reset = 1'b0;
    #1;
    m_reset();
    chk("midrst_vout", 32'(valid_out), 32'h0);
    chk("midrst_item", 32'(item_out), 32'h0);
    chk("midrst_busy", 32'(channel_busy), 32'hF);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) begin
      apply(4'b0000, 1'b0, 1'b1);
      chk("midrst_gone", 32'(valid_out), 32'h0);
      advance();
    end
    chk("midrst_fwd", 32'(fwd_count), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
